ucc_serial_ctrl: RTL and testbench

Bit-serial sequencer for the 1-bit universal combinational cell (UCC1Bit).
- Accepts two WIDTH-bit operands, a 2-bit cell mode and an initial carry.
- Walks the operands through a single external cell LSB-first, one bit per clock.
- Closes the carry loop through an internal flop and assembles the result word.
- Sits between the bus-side operation request and one UCC1Bit instance, so a single 1-bit cell serves a full word.

---
 rtl/ucc_pkg.sv | 17 +
 rtl/ucc_serial_shreg.sv | 34 +++
 rtl/ucc_serial_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ucc_serial_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ucc_pkg.sv
// Shared types for the bit-serial UCC1Bit controller: FSM states and cell mode codes.
package ucc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ucc_state_t;

  typedef logic [1:0] ucc_mode_t;

  localparam ucc_mode_t UCC_M0 = 2'd0;
  localparam ucc_mode_t UCC_M1 = 2'd1;
  localparam ucc_mode_t UCC_M2 = 2'd2;
  localparam ucc_mode_t UCC_M3 = 2'd3;

endpackage

// File: rtl/ucc_serial_shreg.sv
// WIDTH-bit right-shift register with clear, parallel load and MSB shift-in.
// Priority is clear, then load, then shift.
module ucc_serial_shreg
  import ucc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadVal,
  input  logic             i_shift,
  input  logic             i_shiftIn,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_loadVal;
    end else if (i_shift) begin
      r_q <= {i_shiftIn, r_q[WIDTH-1:1]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ucc_serial_ctrl.sv
// Bit-serial sequencer walking two WIDTH-bit operands LSB-first through one external UCC1Bit cell.
// Optional macro UCC_CTRL_ABORT_EN adds an i_abort port that cancels a RUN in progress.
module ucc_serial_ctrl
  import ucc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
`ifdef UCC_CTRL_ABORT_EN
  input  logic             i_abort,
`endif
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_opA,
  input  logic [WIDTH-1:0] i_opB,
  input  ucc_mode_t        i_mode,
  input  logic             i_cinInit,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carryOut,
  output logic             o_cellCin,
  output logic             o_cellFin,
  output logic             o_cellPin,
  output ucc_mode_t        o_cellM,
  input  logic             i_cellCout,
  input  logic             i_cellFout
);

  localparam int CW = $clog2(WIDTH);

  ucc_state_t       r_state;
  ucc_state_t       w_nextState;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_carryOut;
  ucc_mode_t        r_mode;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic             w_inRun;
  logic             w_abort;
  logic             w_abortRun;
  logic [WIDTH-1:0] w_aQ;
  logic [WIDTH-1:0] w_bQ;
  logic             w_unused;

`ifdef UCC_CTRL_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_inRun    = (r_state == RUN);
  assign w_abortRun = w_inRun & w_abort;
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        o_busy = 1'b1;
        if (w_abort) begin
          w_nextState = IDLE;
        end else begin
          w_shift = 1'b1;
          if (w_last) begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Carry loop closes through r_carry; the counter parks at WIDTH-1 until the next accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_carryOut <= 1'b0;
      r_mode     <= UCC_M0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_carry <= i_cinInit;
      r_mode  <= i_mode;
    end else if (w_abortRun) begin
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_carryOut <= 1'b0;
    end else if (w_shift) begin
      r_carry <= i_cellCout;
      if (w_last) begin
        r_carryOut <= i_cellCout;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  ucc_serial_shreg #(.WIDTH(WIDTH)) u_aSh (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (1'b0),
    .i_load    (w_accept),
    .i_loadVal (i_opA),
    .i_shift   (w_shift),
    .i_shiftIn (1'b0),
    .o_q       (w_aQ)
  );

  ucc_serial_shreg #(.WIDTH(WIDTH)) u_bSh (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (1'b0),
    .i_load    (w_accept),
    .i_loadVal (i_opB),
    .i_shift   (w_shift),
    .i_shiftIn (1'b0),
    .o_q       (w_bQ)
  );

  // Result fills from the MSB so bit k settles at result[k] after the final shift.
  ucc_serial_shreg #(.WIDTH(WIDTH)) u_resultSh (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_accept | w_abortRun),
    .i_load    (1'b0),
    .i_loadVal ('0),
    .i_shift   (w_shift),
    .i_shiftIn (i_cellFout),
    .o_q       (o_result)
  );

  assign w_unused   = ^{w_aQ[WIDTH-1:1], w_bQ[WIDTH-1:1]};

  assign o_carryOut = r_carryOut;
  assign o_cellFin  = w_inRun & w_aQ[0];
  assign o_cellPin  = w_inRun & w_bQ[0];
  assign o_cellCin  = w_inRun & r_carry;
  assign o_cellM    = r_mode;

endmodule

// File: tb/tb_ucc_serial_ctrl.sv
// Scoreboard bench for ucc_serial_ctrl with a full-adder cell model; expected sums come from plain arithmetic.
// Define UCC_CTRL_ABORT_EN to also exercise the abort path.
module tb_ucc_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic [1:0]   mode;
  logic         cinInit;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carryOut;
  logic         cellCin;
  logic         cellFin;
  logic         cellPin;
  logic [1:0]   cellM;
  logic         cellCout;
  logic         cellFout;
`ifdef UCC_CTRL_ABORT_EN
  logic         abort;
`endif

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int nextFree = 0;

  typedef struct {
    longint     a;
    longint     b;
    bit         cin;
    logic [1:0] mode;
    int         acceptCyc;
  } expT;

  expT sb[$];

  ucc_serial_ctrl #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
`ifdef UCC_CTRL_ABORT_EN
    .i_abort    (abort),
`endif
    .i_start    (start),
    .i_opA      (opA),
    .i_opB      (opB),
    .i_mode     (mode),
    .i_cinInit  (cinInit),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_carryOut (carryOut),
    .o_cellCin  (cellCin),
    .o_cellFin  (cellFin),
    .o_cellPin  (cellPin),
    .o_cellM    (cellM),
    .i_cellCout (cellCout),
    .i_cellFout (cellFout)
  );

  // Full-adder stand-in for the UCC1Bit cell
  assign cellFout = cellFin ^ cellPin ^ cellCin;
  assign cellCout = (cellFin & cellPin) | (cellFin & cellCin) | (cellPin & cellCin);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Carry entering bit k of a+b+cin, from the sum of the low k bits
  function automatic logic carryInto(input longint a, input longint b, input bit cin, input int k);
    longint m;
    m = (longint'(1) << k) - 1;
    return 1'(((a & m) + (b & m) + longint'(cin)) >> k);
  endfunction

  expT    mon;
  longint monSum;
  int     monK;

  // Monitor: pops an expectation whenever done appears, and checks cell drive each cycle
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("spuriousDone", done, 0);
        end else begin
          mon    = sb.pop_front();
          monSum = mon.a + mon.b + longint'(mon.cin);
          checkOutput("doneLatency", cyc, mon.acceptCyc + W + 1);
          checkOutput("result", result, monSum & ((longint'(1) << W) - 1));
          checkOutput("carryOut", carryOut, (monSum >> W) & 1);
          checkOutput("doneBusy", busy, 1);
          checkOutput("doneCellM", cellM, mon.mode);
        end
      end else if (sb.size() > 0) begin
        mon = sb[0];
        if (cyc >= mon.acceptCyc + W + 1) begin
          checkOutput("doneTimeout", done, 1);
          void'(sb.pop_front());
        end else if (cyc > mon.acceptCyc) begin
          monK = cyc - mon.acceptCyc - 1;
          checkOutput("runBusy", busy, 1);
          checkOutput("runCellM", cellM, mon.mode);
          checkOutput("runCellFin", cellFin, (mon.a >> monK) & 1);
          checkOutput("runCellPin", cellPin, (mon.b >> monK) & 1);
          checkOutput("runCellCin", cellCin, carryInto(mon.a, mon.b, mon.cin, monK));
        end else begin
          checkOutput("idleBusy", busy, 0);
          checkOutput("idleCellFin", cellFin, 0);
          checkOutput("idleCellCin", cellCin, 0);
        end
      end else begin
        checkOutput("idleBusy", busy, 0);
        checkOutput("idleCellPin", cellPin, 0);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input logic [1:0] m, input int gap, input bit hold);
    expT e;
    while (cyc < nextFree + gap) begin
      start = 1'b0;
      @(negedge clk);
    end
    opA     = a;
    opB     = b;
    cinInit = cin;
    mode    = m;
    start   = 1'b1;
    e.a         = longint'(a);
    e.b         = longint'(b);
    e.cin       = cin;
    e.mode      = m;
    e.acceptCyc = cyc;
    sb.push_back(e);
    nextFree = cyc + W + 2;
    @(negedge clk);
    while (cyc < nextFree) begin
      start   = hold ? 1'b1 : 1'($urandom);
      opA     = W'($urandom);
      opB     = W'($urandom);
      mode    = 2'($urandom);
      cinInit = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Busy"}, busy, 0);
    checkOutput({tag, "Done"}, done, 0);
    checkOutput({tag, "Result"}, result, 0);
    checkOutput({tag, "CarryOut"}, carryOut, 0);
    checkOutput({tag, "CellDrive"}, {cellFin, cellPin, cellCin}, 0);
    checkOutput({tag, "CellM"}, cellM, 0);
  endtask

  initial begin
    expT e;
    rst     = 1'b1;
    start   = 1'b0;
    opA     = '0;
    opB     = '0;
    mode    = 2'd0;
    cinInit = 1'b0;
`ifdef UCC_CTRL_ABORT_EN
    abort   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkResetState("rst");
    rst      = 1'b0;
    nextFree = cyc;

    // Reset in the middle of a RUN, after three bits have been processed
    opA = 8'hA5; opB = 8'h3C; cinInit = 1'b1; mode = 2'd3; start = 1'b1;
    e.a = 64'hA5; e.b = 64'h3C; e.cin = 1'b1; e.mode = 2'd3; e.acceptCyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    checkResetState("midRunRst");
    @(negedge clk);
    rst      = 1'b0;
    nextFree = cyc;

    applyStimulus(8'h05, 8'h03, 1'b0, 2'd2, 0, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 2'($urandom), 1, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b1, 2'($urandom), 0, 1'b0);
    repeat (3) applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 2'($urandom), 0, 1'b1);
    repeat (30) applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 2'($urandom),
                              $urandom_range(0, 2), 1'($urandom));
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    checkOutput("drainEmpty", sb.size(), 0);

`ifdef UCC_CTRL_ABORT_EN
    // Abort during RUN cycle 4: back to IDLE with no done pulse and a cleared result
    nextFree = cyc;
    opA = 8'hC3; opB = 8'h5A; cinInit = 1'b1; mode = 2'd1; start = 1'b1;
    e.a = 64'hC3; e.b = 64'h5A; e.cin = 1'b1; e.mode = 2'd1; e.acceptCyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    sb.delete();
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortResult", result, 0);
    checkOutput("abortCarryOut", carryOut, 0);
    repeat (W + 2) @(negedge clk);
    nextFree = cyc;
    applyStimulus(8'h12, 8'h34, 1'b0, 2'd0, 0, 1'b0);
    repeat (W + 4) @(negedge clk);
    checkOutput("abortDrainEmpty", sb.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
